// File: rtl/vga_hex_reg.sv
// vga_hex_reg: draws a NIBBLES-digit hex value as 8x8 glyphs on a 26-bit RGB pixel stream, 2-cycle latency.
// Define VGA_HEX_REG_BORDER_EN to add a 1-pixel FG rectangle around the digit box.
module vga_hex_reg #(
    parameter int          NIBBLES = 2,
    parameter int          SEP     = 2,
    parameter logic [2:0]  FG      = 3'b111,
    parameter logic [2:0]  BG      = 3'b000
) (
    input  logic                   px_clk,
    input  logic                   reset,
    input  logic [25:0]            strRGB_in,
    input  logic [4*NIBBLES-1:0]   value,
    input  logic [9:0]             x_pos,
    input  logic [9:0]             y_pos,
    output logic [25:0]            strRGB
);

    localparam int         PITCH = 8 + SEP;
    localparam int         W     = NIBBLES * 8 + (NIBBLES - 1) * SEP;
    localparam logic [10:0] W11  = 11'(W);
    localparam int         DW    = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;

    function automatic logic [7:0] glyph_row(input logic [3:0] n, input logic [2:0] r);
        logic [63:0] g;
        case (n)
            4'h0:    g = 64'h3C666E7666663C00;
            4'h1:    g = 64'h183818181818_7E00;
            4'h2:    g = 64'h3C66060C30607E00;
            4'h3:    g = 64'h3C66061C06663C00;
            4'h4:    g = 64'h0C1C3C6C7E0C0C00;
            4'h5:    g = 64'h7E607C0606663C00;
            4'h6:    g = 64'h3C607C6666663C00;
            4'h7:    g = 64'h7E060C1830303000;
            4'h8:    g = 64'h3C66663C66663C00;
            4'h9:    g = 64'h3C66663E060C3800;
            4'hA:    g = 64'h183C66667E666600;
            4'hB:    g = 64'h7C66667C66667C00;
            4'hC:    g = 64'h3C66606060663C00;
            4'hD:    g = 64'h786C6666666C7800;
            4'hE:    g = 64'h7E60607C60607E00;
            default: g = 64'h7E60607C60606000;
        endcase
        return g[8*(7-int'(r)) +: 8];
    endfunction

    // Per-frame snapshot of the displayed value and box position
    logic [4*NIBBLES-1:0] value_q, value_d;
    logic [9:0]           xs_q, xs_d, ys_q, ys_d;
    logic                 frame_start;

    assign frame_start = (strRGB_in[22:3] == 20'd0);

    always_comb begin
        value_d = value_q;
        xs_d    = xs_q;
        ys_d    = ys_q;
        if (frame_start) begin
            value_d = value;
            xs_d    = x_pos;
            ys_d    = y_pos;
        end
    end

    always_ff @(posedge px_clk) begin
        if (reset) begin
            value_q <= '0;
            xs_q    <= '0;
            ys_q    <= '0;
        end else begin
            value_q <= value_d;
            xs_q    <= xs_d;
            ys_q    <= ys_d;
        end
    end

    // ---- Stage 1: geometry (11-bit so box edges past 1023 never wrap) ----
    logic [10:0]   xc, yc, xs, ys, rel_x, rel_y, colw;
    logic          in_box_d, in_sep_d;
    logic [DW-1:0] dig;
    logic [3:0]    nib_d;
`ifdef VGA_HEX_REG_BORDER_EN
    logic          border_d, border_p1_q;
`endif

    always_comb begin
        xc    = {1'b0, strRGB_in[22:13]};
        yc    = {1'b0, strRGB_in[12:3]};
        xs    = {1'b0, xs_q};
        ys    = {1'b0, ys_q};
        rel_x = xc - xs;
        rel_y = yc - ys;
        in_box_d = (xc >= xs) && (xc < xs + W11) && (yc >= ys) && (yc < ys + 11'd8);
        dig  = '0;
        colw = rel_x;
        for (int d = 1; d < NIBBLES; d++) begin
            if (rel_x >= 11'(d * PITCH)) begin
                dig  = DW'(d);
                colw = rel_x - 11'(d * PITCH);
            end
        end
        in_sep_d = (colw[10:3] != 8'd0);
        nib_d = value_q[4*NIBBLES-1 -: 4];
        for (int d = 1; d < NIBBLES; d++) begin
            if (dig == DW'(d)) nib_d = value_q[4*(NIBBLES-d)-1 -: 4];
        end
`ifdef VGA_HEX_REG_BORDER_EN
        // Left/top edges compare xc+1 / yc+1 so a zero position suppresses them instead of wrapping
        border_d = (xc + 11'd1 >= xs) && (xc <= xs + W11) &&
                   (yc + 11'd1 >= ys) && (yc <= ys + 11'd8) &&
                   ((xc + 11'd1 == xs) || (xc == xs + W11) ||
                    (yc + 11'd1 == ys) || (yc == ys + 11'd8));
`endif
    end

    logic [25:0] str_p1_q;
    logic        in_box_p1_q, in_sep_p1_q;
    logic [3:0]  nib_p1_q;
    logic [2:0]  row_p1_q, col_p1_q;

    always_ff @(posedge px_clk) begin
        if (reset) begin
            str_p1_q    <= '0;
            in_box_p1_q <= 1'b0;
            in_sep_p1_q <= 1'b0;
            nib_p1_q    <= '0;
            row_p1_q    <= '0;
            col_p1_q    <= '0;
`ifdef VGA_HEX_REG_BORDER_EN
            border_p1_q <= 1'b0;
`endif
        end else begin
            str_p1_q    <= strRGB_in;
            in_box_p1_q <= in_box_d;
            in_sep_p1_q <= in_sep_d;
            nib_p1_q    <= nib_d;
            row_p1_q    <= rel_y[2:0];
            col_p1_q    <= colw[2:0];
`ifdef VGA_HEX_REG_BORDER_EN
            border_p1_q <= border_d;
`endif
        end
    end

    // ---- Stage 2: glyph lookup and colour select ----
    logic [7:0]  glyph;
    logic        pix;
    logic [2:0]  rgb_d;
    logic [25:0] out_q, out_d;

    always_comb begin
        glyph = glyph_row(nib_p1_q, row_p1_q);
        pix   = glyph[3'd7 - col_p1_q];
        rgb_d = str_p1_q[25:23];
        if (!str_p1_q[0])
            rgb_d = 3'b000;
`ifdef VGA_HEX_REG_BORDER_EN
        else if (border_p1_q)
            rgb_d = FG;
`endif
        else if (in_box_p1_q && !in_sep_p1_q && pix)
            rgb_d = FG;
        else if (in_box_p1_q)
            rgb_d = BG;
        out_d = {rgb_d, str_p1_q[22:0]};
    end

    always_ff @(posedge px_clk) begin
        if (reset) out_q <= '0;
        else       out_q <= out_d;
    end

    assign strRGB = out_q;

endmodule

// File: tb/tb_vga_hex_reg.sv
// Directed bench for vga_hex_reg: single instance plus a two-instance chain fed from its output.
module tb_vga_hex_reg;

    logic        px_clk;
    logic        reset;
    logic [25:0] strRGB_in;
    logic [7:0]  v0, v1;
    logic [9:0]  x0, y0, x1, y1;
    logic [25:0] out0, out1;

    vga_hex_reg #(.NIBBLES(2), .SEP(2), .FG(3'b111), .BG(3'b000)) u0 (
        .px_clk(px_clk), .reset(reset), .strRGB_in(strRGB_in),
        .value(v0), .x_pos(x0), .y_pos(y0), .strRGB(out0));

    vga_hex_reg #(.NIBBLES(2), .SEP(2), .FG(3'b111), .BG(3'b000)) u1 (
        .px_clk(px_clk), .reset(reset), .strRGB_in(out0),
        .value(v1), .x_pos(x1), .y_pos(y1), .strRGB(out1));

    initial px_clk = 1'b0;
    always #5 px_clk = ~px_clk;

    localparam logic [2:0] P  = 3'b101;
    localparam logic [2:0] R  = 3'b001;
    localparam logic [2:0] F  = 3'b111;
    localparam logic [2:0] BK = 3'b000;
`ifdef VGA_HEX_REG_BORDER_EN
    localparam logic [2:0] BRD = F;
`else
    localparam logic [2:0] BRD = P;
`endif

    int checks   = 0;
    int failures = 0;
    int n        = 0;

    logic [25:0] hist_in  [0:255];
    logic [2:0]  hist_e0  [0:255];
    logic [2:0]  hist_e1  [0:255];
    logic        hist_c0  [0:255];
    logic        hist_c1  [0:255];
    string       hist_tag [0:255];

    task automatic step(input logic [9:0] x, input logic [9:0] y, input logic [2:0] rgb,
                        input logic act, input logic rst_v, input logic c0, input logic [2:0] e0,
                        input logic c1, input logic [2:0] e1, input string tag);
        logic [25:0] w, exp;
        w = {rgb, x, y, 2'b00, act};
        strRGB_in = w;
        reset     = rst_v;
        @(posedge px_clk);
        #1;
        hist_in[n]  = rst_v ? 26'd0 : w;
        hist_e0[n]  = rst_v ? 3'b000 : e0;
        hist_c0[n]  = c0 | rst_v;
        hist_e1[n]  = e1;
        hist_c1[n]  = c1;
        hist_tag[n] = tag;
        if (rst_v) begin
            checks++;
            assert (out0 === 26'd0) else begin
                failures++;
                $error("FAIL %s_rst out=%h expected=%h", tag, out0, 26'd0);
            end
        end else if (n >= 1 && hist_c0[n-1]) begin
            exp = {hist_e0[n-1], hist_in[n-1][22:0]};
            checks++;
            assert (out0 === exp) else begin
                failures++;
                $error("FAIL %s out=%h expected=%h", hist_tag[n-1], out0, exp);
            end
        end
        if (n >= 3 && hist_c1[n-3]) begin
            exp = {hist_e1[n-3], hist_in[n-3][22:0]};
            checks++;
            assert (out1 === exp) else begin
                failures++;
                $error("FAIL %s_chain out=%h expected=%h", hist_tag[n-3], out1, exp);
            end
        end
        n++;
    endtask

    task automatic chk(input logic [9:0] x, input logic [9:0] y, input logic [2:0] e, input string tag);
        step(x, y, P, 1'b1, 1'b0, 1'b1, e, 1'b0, 3'b000, tag);
    endtask

    task automatic nop(input logic [9:0] x, input logic [9:0] y, input logic [2:0] rgb);
        step(x, y, rgb, 1'b1, 1'b0, 1'b0, 3'b000, 1'b0, 3'b000, "nop");
    endtask

    task automatic rst(input logic [9:0] x, input logic [9:0] y, input string tag);
        step(x, y, P, 1'b1, 1'b1, 1'b1, 3'b000, 1'b0, 3'b000, tag);
    endtask

    task automatic chn(input logic [9:0] x, input logic [9:0] y, input logic [2:0] e0,
                       input logic [2:0] e1, input string tag);
        step(x, y, R, 1'b1, 1'b0, 1'b1, e0, 1'b1, e1, tag);
    endtask

    initial begin
        strRGB_in = '0;
        reset = 1'b1;
        v0 = 8'h00; x0 = 10'd0;   y0 = 10'd0;
        v1 = 8'h00; x1 = 10'd500; y1 = 10'd500;

        // Reset; a frame-start pixel during reset must not be captured
        rst(10'd5, 10'd5, "reset_a");
        v0 = 8'hFF; x0 = 10'd300; y0 = 10'd300;
        rst(10'd0, 10'd0, "reset_snap");
        rst(10'd6, 10'd6, "reset_b");
        chk(10'd2,  10'd0, F,  "post_reset_box00_fg");
        chk(10'd1,  10'd7, BK, "post_reset_row7_bg");
        chk(10'd18, 10'd0, P,  "post_reset_outside");

        // Value 00 at (100,50)
        v0 = 8'h00; x0 = 10'd100; y0 = 10'd50;
        nop(10'd0, 10'd0, P);
        chk(10'd102, 10'd50, F,  "t1_fg");
        chk(10'd100, 10'd50, BK, "t1_bg");
        chk(10'd108, 10'd52, BK, "t1_sep");
        chk(10'd99,  10'd50, P,  "t1_left_out");
        chk(10'd117, 10'd50, BK, "t1_right_in");
        chk(10'd118, 10'd50, P,  "t1_right_out");
        chk(10'd102, 10'd49, P,  "t1_above");
        chk(10'd102, 10'd58, P,  "t1_below");
        step(10'd102, 10'd50, P, 1'b0, 1'b0, 1'b1, 3'b000, 1'b0, 3'b000, "t1_inactive");

        // Value 1F
        v0 = 8'h1F;
        nop(10'd0, 10'd0, P);
        chk(10'd103, 10'd50, F,  "t2_one_c3");
        chk(10'd104, 10'd50, F,  "t2_one_c4");
        chk(10'd105, 10'd50, BK, "t2_one_c5");
        chk(10'd110, 10'd50, BK, "t2_f_c0");
        chk(10'd111, 10'd50, F,  "t2_f_c1");
        chk(10'd116, 10'd50, F,  "t2_f_c6");
        chk(10'd117, 10'd50, BK, "t2_f_c7");
        chk(10'd105, 10'd57, BK, "t2_row7_a");
        chk(10'd113, 10'd57, BK, "t2_row7_b");

        // Mid-frame value change must not tear
        v0 = 8'h00;
        nop(10'd0, 10'd0, P);
        nop(10'd104, 10'd51, P);
        v0 = 8'hFF;
        chk(10'd104, 10'd52, F,  "t3_old_row2");
        chk(10'd104, 10'd53, BK, "t3_old_row3");
        nop(10'd0, 10'd0, P);
        chk(10'd104, 10'd52, BK, "t3_new_row2");
        chk(10'd104, 10'd53, F,  "t3_new_row3");

        // Box running past the right edge
        v0 = 8'h00; x0 = 10'd790;
        nop(10'd0, 10'd0, P);
        chk(10'd792, 10'd50, F,  "edge_fg");
        chk(10'd799, 10'd50, BK, "edge_bg");

        // Two chained instances on a red background
        v0 = 8'hAB; x0 = 10'd100; y0 = 10'd10;
        v1 = 8'h1F; x1 = 10'd200; y1 = 10'd30;
        nop(10'd0, 10'd0, R);
        chn(10'd50,  10'd5,  R,  R,  "t4_outside");
        chn(10'd102, 10'd10, BK, BK, "t4_a_bg");
        chn(10'd103, 10'd10, F,  F,  "t4_a_fg");
        chn(10'd113, 10'd10, F,  F,  "t4_b_fg");
        chn(10'd203, 10'd30, R,  F,  "t4_u1_fg");
        chn(10'd200, 10'd30, R,  BK, "t4_u1_bg");
        chn(10'd211, 10'd30, R,  F,  "t4_u1_f");
        chn(10'd103, 10'd30, R,  R,  "t4_between");
        nop(10'd400, 10'd400, R);
        nop(10'd401, 10'd400, R);
        nop(10'd402, 10'd400, R);

        // Reset mid-frame
        v0 = 8'h00; x0 = 10'd100; y0 = 10'd50;
        nop(10'd103, 10'd10, P);
        rst(10'd300, 10'd200, "t5_rst0");
        rst(10'd301, 10'd200, "t5_rst1");
        rst(10'd302, 10'd200, "t5_rst2");
        chk(10'd2,   10'd2,  F,  "t5_box00_fg");
        chk(10'd3,   10'd2,  BK, "t5_box00_bg");
        chk(10'd102, 10'd50, P,  "t5_old_pos_gone");
        nop(10'd0, 10'd0, P);
        chk(10'd102, 10'd50, F,  "t5_resnap_fg");
        chk(10'd2,   10'd2,  P,  "t5_resnap_origin");

        // Border region at x_pos=0, y_pos=20
        x0 = 10'd0; y0 = 10'd20;
        nop(10'd0, 10'd0, P);
        chk(10'd0,    10'd19, BRD, "t6_top_left");
        chk(10'd18,   10'd19, BRD, "t6_top_right");
        chk(10'd18,   10'd24, BRD, "t6_right_col");
        chk(10'd5,    10'd28, BRD, "t6_bottom");
        chk(10'd19,   10'd19, P,   "t6_past_right");
        chk(10'd1023, 10'd19, P,   "t6_no_wrap_top");
        chk(10'd1023, 10'd20, P,   "t6_no_wrap_left");
        chk(10'd0,    10'd20, BK,  "t6_box_first_col");
        chk(10'd17,   10'd20, BK,  "t6_box_last_col");
        nop(10'd500, 10'd500, P);
        nop(10'd501, 10'd500, P);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
